// File: rtl/iq_capture_pkg.sv
// iq_capture_pkg
// Shared definitions for the IQ burst capture block: default sample width and
// buffer depth, the capture FSM state encoding, and the packed {I,Q} sample
// type (I in the upper half) at the default width.
package iq_capture_pkg;

  localparam int DW_DEFAULT    = 14;
  localparam int DEPTH_DEFAULT = 1024;

  // Encoding is visible on the 'state' output, so the values are fixed.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_READOUT = 2'd3
  } cap_state_e;

  typedef struct packed {
    logic signed [DW_DEFAULT-1:0] i;
    logic signed [DW_DEFAULT-1:0] q;
  } iq_sample_t;

endpackage

// File: rtl/iq_capture_ram.sv
// iq_capture_ram
// Simple dual-port sample buffer: one write port, one read port with a
// registered output (one cycle of read latency). No reset on the array or the
// read register so the tools can map it onto block RAM.
// Ports:
//   clk      - sample clock
//   wr_en    - write strobe, wr_addr/wr_data written on the rising edge
//   rd_en    - read strobe, rd_data updates on the following edge
//   rd_data  - registered read data, holds when rd_en is low
module iq_capture_ram
  import iq_capture_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int W     = 2 * DW_DEFAULT
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [W-1:0]             rd_data
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/iq_burst_capture.sv
// iq_burst_capture
// Arms on 'arm', triggers when the registered |I| reaches 'threshold' (or on
// force_trig), captures cap_len consecutive {I,Q} samples into a buffer, then
// streams them out over a valid/ready interface and returns to idle.
// Ports:
//   clkin320, reset_n      - sample clock, async active-low reset
//   i_in, q_in             - continuous signed sample stream, one per cycle
//   arm, force_trig        - start a sequence / trigger immediately when armed
//   threshold              - unsigned trigger level against saturated |I|
//   cap_len                - burst length, 0 acts as 1, above DEPTH acts as DEPTH
//   out_data/valid/last    - readout stream, {I,Q} with I in the MSBs
//   out_ready              - downstream acceptance
//   state                  - current FSM state, done - one-cycle completion pulse
module iq_burst_capture
  import iq_capture_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int DW    = DW_DEFAULT
) (
  input  logic                       clkin320,
  input  logic                       reset_n,
  input  logic [DW-1:0]              i_in,
  input  logic [DW-1:0]              q_in,
  input  logic                       arm,
  input  logic                       force_trig,
  input  logic [DW-2:0]              threshold,
  input  logic [$clog2(DEPTH):0]     cap_len,
  output logic [2*DW-1:0]            out_data,
  output logic                       out_valid,
  output logic                       out_last,
  input  logic                       out_ready,
  output logic [1:0]                 state,
  output logic                       done
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [DW-1:0] MIN_I = {1'b1, {(DW-1){1'b0}}};

  cap_state_e state_q, state_d;

  logic [DW-1:0]   i_r, q_r;
  logic [DW-2:0]   abs_i;
  logic            trig;
  logic [AW-1:0]   len_m1_in, len_m1;
  logic [AW-1:0]   wr_addr, ram_wa, rd_addr;
  logic            wr_en, rd_issue, rd_done, rd_pend, rd_pend_last;
  logic [2*DW-1:0] ram_q;
  logic [2*DW-1:0] fifo_data [2];
  logic            fifo_last [2];
  logic            wptr, rptr;
  logic [1:0]      cnt;
  logic [2:0]      occ;
  logic            pop;
  logic            done_q;

  // Saturating magnitude of the registered I sample: the most negative code
  // has no positive twin, so it clips to the largest positive magnitude.
  // For other negatives the low DW-1 bits of the two's-complement negation
  // are the magnitude.
  always_comb begin
    abs_i = i_r[DW-2:0];
    if (i_r[DW-1]) begin
      if (i_r == MIN_I) abs_i = '1;
      else              abs_i = ~i_r[DW-2:0] + (DW-1)'(1);
    end
  end

  // Burst length minus one, clamped. A length of exactly DEPTH has zero low
  // bits, so subtracting one wraps to DEPTH-1 as wanted.
  always_comb begin
    if (cap_len == '0)                     len_m1_in = '0;
    else if (cap_len >= (AW+1)'(DEPTH))    len_m1_in = '1;
    else                                   len_m1_in = cap_len[AW-1:0] - AW'(1);
  end

  assign trig      = (abs_i >= threshold) || force_trig;
  assign out_valid = (cnt != 2'd0);
  assign out_data  = fifo_data[rptr];
  assign out_last  = out_valid && fifo_last[rptr];
  assign pop       = out_valid && out_ready;
  assign state     = state_q;
  assign done      = done_q;

  // Slots that will be committed after this edge; a read issued now lands in
  // the skid FIFO one cycle later, so this keeps it from ever overflowing
  // while still allowing one read per cycle when the consumer keeps up.
  assign occ = {1'b0, cnt} + {2'b0, rd_pend} - {2'b0, pop};

  // The sample that triggers is written at address 0 in the same cycle.
  assign ram_wa = (state_q == ST_ARMED) ? '0 : wr_addr;

  // FSM state register.
  always_ff @(posedge clkin320 or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state and control strobes. A one-sample burst skips CAPTURE since
  // its only sample is written on the trigger cycle.
  always_comb begin
    state_d  = state_q;
    wr_en    = 1'b0;
    rd_issue = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (arm) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (trig) begin
          wr_en   = 1'b1;
          state_d = (len_m1_in == '0) ? ST_READOUT : ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        wr_en = 1'b1;
        if (wr_addr == len_m1) state_d = ST_READOUT;
      end
      ST_READOUT: begin
        rd_issue = !rd_done && (occ < 3'd2);
        if (pop && out_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sample register, address counters, read pipeline and the 2-entry skid
  // FIFO feeding the output. The FIFO is reset so out_data reads zero.
  always_ff @(posedge clkin320 or negedge reset_n) begin
    if (!reset_n) begin
      i_r          <= '0;
      q_r          <= '0;
      len_m1       <= '0;
      wr_addr      <= '0;
      rd_addr      <= '0;
      rd_done      <= 1'b0;
      rd_pend      <= 1'b0;
      rd_pend_last <= 1'b0;
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_last[0] <= 1'b0;
      fifo_last[1] <= 1'b0;
      wptr         <= 1'b0;
      rptr         <= 1'b0;
      cnt          <= 2'd0;
      done_q       <= 1'b0;
    end else begin
      i_r    <= i_in;
      q_r    <= q_in;
      done_q <= pop && out_last;

      if (state_q == ST_ARMED && trig) begin
        len_m1  <= len_m1_in;
        wr_addr <= AW'(1);
        rd_addr <= '0;
        rd_done <= 1'b0;
      end else if (wr_en) begin
        wr_addr <= wr_addr + AW'(1);
      end

      if (rd_issue) begin
        rd_addr <= rd_addr + AW'(1);
        if (rd_addr == len_m1) rd_done <= 1'b1;
      end
      rd_pend      <= rd_issue;
      rd_pend_last <= rd_issue && (rd_addr == len_m1);

      if (rd_pend) begin
        fifo_data[wptr] <= ram_q;
        fifo_last[wptr] <= rd_pend_last;
        wptr            <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      cnt <= cnt + {1'b0, rd_pend} - {1'b0, pop};
    end
  end

  iq_capture_ram #(
    .DEPTH (DEPTH),
    .W     (2*DW)
  ) u_ram (
    .clk     (clkin320),
    .wr_en   (wr_en),
    .wr_addr (ram_wa),
    .wr_data ({i_r, q_r}),
    .rd_en   (rd_issue),
    .rd_addr (rd_addr),
    .rd_data (ram_q)
  );

endmodule

// File: tb/tb_iq_burst_capture.sv
`timescale 1ns/1ps
// tb_iq_burst_capture
// Table of burst scenarios (trigger setup, stimulus ramp, expected first
// sample and burst length) plus hand-written reset and idle sequences.
module tb_iq_burst_capture;

  localparam int DW    = 14;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic              clkin320 = 1'b0;
  logic              reset_n  = 1'b0;
  logic [DW-1:0]     i_in     = '0;
  logic [DW-1:0]     q_in     = '0;
  logic              arm      = 1'b0;
  logic              force_trig = 1'b0;
  logic [DW-2:0]     threshold = '0;
  logic [AW:0]       cap_len  = '0;
  logic [2*DW-1:0]   out_data;
  logic              out_valid;
  logic              out_last;
  logic              out_ready = 1'b1;
  logic [1:0]        state;
  logic              done;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [DW-2:0] thr;
    logic          frc;
    logic [AW:0]   clen;
    logic [DW-1:0] start;
    logic [DW-1:0] step;
    logic          rand_ready;
    logic          disturb;
    logic [DW-1:0] first_i;
    int            exp_len;
  } vec_t;

  vec_t vecs[8];

  iq_burst_capture #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clkin320   (clkin320),
    .reset_n    (reset_n),
    .i_in       (i_in),
    .q_in       (q_in),
    .arm        (arm),
    .force_trig (force_trig),
    .threshold  (threshold),
    .cap_len    (cap_len),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .state      (state),
    .done       (done)
  );

  always #2 clkin320 = ~clkin320;

  // Step to just after the next rising edge.
  task automatic tick();
    @(posedge clkin320);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Runs one complete burst from arm to done and scores it.
  task automatic applyStimulus(input vec_t v, input int idx);
    logic [DW-1:0]   cur;
    logic [DW-1:0]   exp_i;
    logic [2*DW-1:0] prev_data;
    bit   finished, seen_ro, prev_stall, disturbed;
    int   k, cycles, ro_cycles, first_valid_at;
    int   data_err, last_err, stab_err, outside_err;
    finished = 0; seen_ro = 0; prev_stall = 0; disturbed = 0;
    k = 0; cycles = 0; ro_cycles = 0; first_valid_at = -1;
    data_err = 0; last_err = 0; stab_err = 0; outside_err = 0;
    prev_data = '0;

    threshold  = v.thr;
    cap_len    = v.clen;
    out_ready  = 1'b1;
    cur        = v.start;
    i_in       = cur;
    q_in       = ~cur;
    arm        = 1'b1;
    force_trig = v.frc;
    tick();

    while (!finished && cycles < 5000) begin
      cur  = cur + v.step;
      i_in = cur;
      q_in = ~cur;
      if (v.disturb && state == 2'd2 && !disturbed) begin
        arm       = 1'b1;
        cap_len   = 11'd3;
        disturbed = 1;
      end else begin
        arm = 1'b0;
      end
      if (state == 2'd3) begin
        if (!seen_ro) seen_ro = 1;
        else          ro_cycles++;
      end
      if (out_valid && state != 2'd3) outside_err++;
      if (out_valid && first_valid_at < 0) first_valid_at = ro_cycles;
      if (prev_stall && (!out_valid || out_data != prev_data)) stab_err++;
      out_ready = v.rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_ready) begin
        exp_i = v.first_i + DW'(k) * v.step;
        if (out_data != {exp_i, ~exp_i}) begin
          if (data_err == 0)
            $display("[TB] burst %0d sample %0d data %h, wanted %h", idx, k, out_data, {exp_i, ~exp_i});
          data_err++;
        end
        if (out_last != (k == v.exp_len - 1)) last_err++;
        k++;
        if (out_last) finished = 1;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      tick();
      cycles++;
    end
    force_trig = 1'b0;
    out_ready  = 1'b1;

    checkOutput($sformatf("v%0d_complete", idx), int'(finished), 1);
    checkOutput($sformatf("v%0d_len", idx), k, v.exp_len);
    checkOutput($sformatf("v%0d_data_errs", idx), data_err, 0);
    checkOutput($sformatf("v%0d_last_errs", idx), last_err, 0);
    checkOutput($sformatf("v%0d_stall_errs", idx), stab_err, 0);
    checkOutput($sformatf("v%0d_valid_outside", idx), outside_err, 0);
    checkOutput($sformatf("v%0d_latency_ok", idx), int'(first_valid_at >= 0 && first_valid_at <= 3), 1);
    checkOutput($sformatf("v%0d_state_idle", idx), int'(state), 0);
    checkOutput($sformatf("v%0d_done_pulse", idx), int'(done), 1);
    tick();
    checkOutput($sformatf("v%0d_done_clear", idx), int'(done), 0);
  endtask

  initial begin
    int n, cyc, stray;

    //           thr    frc  clen     start        step        rr  dist first         len
    vecs[0] = '{13'd1000, 1'b0, 11'd16,   14'd0,       14'd100,    1'b0, 1'b0, 14'd1000,     16};
    vecs[1] = '{13'd8191, 1'b0, 11'd4,    14'h2000,    14'd0,      1'b0, 1'b0, 14'h2000,     4};
    vecs[2] = '{13'd500,  1'b0, 11'd3,    14'(-400),   14'(-50),   1'b0, 1'b0, 14'(-500),    3};
    vecs[3] = '{13'd0,    1'b0, 11'd5,    14'd123,     14'd7,      1'b0, 1'b0, 14'd123,      5};
    vecs[4] = '{13'd8191, 1'b1, 11'd0,    14'd77,      14'd3,      1'b0, 1'b0, 14'd77,       1};
    vecs[5] = '{13'd8191, 1'b1, 11'd2000, 14'd5,       14'd1,      1'b0, 1'b0, 14'd5,        1024};
    vecs[6] = '{13'd8191, 1'b1, 11'd1024, 14'd0,       14'd1,      1'b1, 1'b0, 14'd0,        1024};
    vecs[7] = '{13'd8191, 1'b1, 11'd32,   14'd300,     14'd2,      1'b0, 1'b1, 14'd300,      32};

    // Reset state.
    repeat (3) @(posedge clkin320);
    #1;
    checkOutput("rst_state", int'(state), 0);
    checkOutput("rst_valid", int'(out_valid), 0);
    checkOutput("rst_last", int'(out_last), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_data", int'(out_data), 0);
    reset_n = 1'b1;

    // Without arm the block stays idle even with force and a low threshold.
    force_trig = 1'b1;
    repeat (4) tick();
    checkOutput("idle_no_arm", int'(state), 0);
    force_trig = 1'b0;

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i], i);

    // Reset while sample 5 of a burst is being presented.
    threshold  = 13'd8191;
    cap_len    = 11'd16;
    out_ready  = 1'b1;
    i_in       = 14'd200;
    arm        = 1'b1;
    force_trig = 1'b1;
    tick();
    arm = 1'b0;
    n = 0; cyc = 0;
    while (n < 5 && cyc < 200) begin
      if (out_valid && out_ready) n++;
      tick();
      cyc++;
    end
    force_trig = 1'b0;
    checkOutput("rst_mid_transfers", n, 5);
    checkOutput("rst_mid_valid_before", int'(out_valid), 1);
    reset_n = 1'b0;
    #1;
    checkOutput("rst_mid_valid", int'(out_valid), 0);
    checkOutput("rst_mid_state", int'(state), 0);
    checkOutput("rst_mid_data", int'(out_data), 0);
    tick();
    tick();
    reset_n = 1'b1;
    stray = 0;
    for (int c = 0; c < 12; c++) begin
      if (out_valid || state != 2'd0) stray++;
      tick();
    end
    checkOutput("rst_mid_quiet", stray, 0);

    // A fresh arm after the aborted burst delivers a full burst.
    applyStimulus('{13'd8191, 1'b1, 11'd16, 14'd40, 14'd5, 1'b0, 1'b0, 14'd40, 16}, 8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
